// File: rtl/ctlr_pad_responder.sv
// ctlr_pad_responder
// ------------------
// Emulates the controller side of an NES serial pad: a parallel-in/serial-out
// shift register that is loaded by the console's latch strobe, advanced by the
// console's pulse strobe and answered on an active-low data line. Button
// inputs are synchronized and debounced before they can be latched.
//
// Console strobes: ctlr_latch high loads the register continuously
// (transparent load) and dominates everything else; while it is low, every
// synchronized rising edge of ctlr_pulse presents the next bit. There is no
// back-pressure, so the console must hold each strobe phase for at least
// SYNC_STAGES + 1 enabled cycles.
//
// Parameters
//   DEBOUNCE_CYCLES  enabled cycles a raw level must persist (1..65535)
//   SYNC_STAGES      synchronizer depth on all asynchronous inputs (>= 2)
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   clock_en     in   all registers advance only when high
//   buttons_raw  in   [7:0] active-high pressed: A,B,Select,Start,Up,Down,Left,Right
//   ctlr_latch   in   parallel-load strobe from the console, active-high
//   ctlr_pulse   in   shift clock from the console, rising edge advances
//   ctlr_data    out  serial data, active-low (0 = pressed)
//   buttons_db   out  [7:0] debounced button state
//   shift_cnt    out  [3:0] bits shifted since the last load, saturating at 8
//   state_dbg    out  [1:0] current state (0 LOAD, 1 SHIFT, 2 DONE)

module ctlr_pad_responder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clock_en,
   input  logic [7:0] buttons_raw,
   input  logic       ctlr_latch,
   input  logic       ctlr_pulse,
   output logic       ctlr_data,
   output logic [7:0] buttons_db,
   output logic [3:0] shift_cnt,
   output logic [1:0] state_dbg
);

   localparam int CW = 16;
   localparam logic [CW:0] DB_LIMIT = (CW + 1)'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] latch_s;
   logic [SYNC_STAGES-1:0] pulse_s;
   logic [7:0]             btn_s [SYNC_STAGES];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         latch_s <= '0;
         pulse_s <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) btn_s[i] <= '0;
      end else if (clock_en) begin
         latch_s  <= {latch_s[SYNC_STAGES-2:0], ctlr_latch};
         pulse_s  <= {pulse_s[SYNC_STAGES-2:0], ctlr_pulse};
         btn_s[0] <= buttons_raw;
         for (int i = 1; i < SYNC_STAGES; i++) btn_s[i] <= btn_s[i-1];
      end
   end

   logic       latch_sync;
   logic       pulse_sync;
   logic [7:0] btn_sync;

   assign latch_sync = latch_s[SYNC_STAGES-1];
   assign pulse_sync = pulse_s[SYNC_STAGES-1];
   assign btn_sync   = btn_s[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive enabled
   // cycles of disagreement with its stable value.
   // ------------------------------------------------------------------
   logic [CW-1:0] db_cnt [8];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buttons_db <= '0;
         for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
      end else if (clock_en) begin
         for (int i = 0; i < 8; i++) begin
            if (btn_sync[i] == buttons_db[i]) begin
               db_cnt[i] <= '0;
            end else if (({1'b0, db_cnt[i]} + 17'd1) == DB_LIMIT) begin
               buttons_db[i] <= ~buttons_db[i];
               db_cnt[i]     <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Pulse edge detect. The history flop updates even while latch is
   // high, so an edge that coincides with latch is consumed, not deferred.
   // ------------------------------------------------------------------
   logic pulse_prev;
   logic pulse_rise;

   assign pulse_rise = pulse_sync & ~pulse_prev;

   // ------------------------------------------------------------------
   // Shift-register state machine
   // ------------------------------------------------------------------
   state_t     state;
   state_t     state_next;
   logic [7:0] sr;
   logic [7:0] sr_next;
   logic [3:0] cnt_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_LOAD;
         sr         <= 8'h00;
         shift_cnt  <= 4'd0;
         pulse_prev <= 1'b0;
      end else if (clock_en) begin
         state      <= state_next;
         sr         <= sr_next;
         shift_cnt  <= cnt_next;
         pulse_prev <= pulse_sync;
      end
   end

   always_comb begin
      state_next = state;
      sr_next    = sr;
      cnt_next   = shift_cnt;

      if (latch_sync) begin
         // Latch dominates from any state; pulse edges are discarded.
         state_next = ST_LOAD;
         sr_next    = buttons_db;
         cnt_next   = 4'd0;
      end else begin
         case (state)
            ST_LOAD, ST_SHIFT: begin
               // Leaving LOAD needs no edge; an edge in the same cycle
               // already counts as the first shift.
               if (state == ST_LOAD) state_next = ST_SHIFT;
               if (pulse_rise) begin
                  sr_next  = {1'b1, sr[7:1]};
                  cnt_next = shift_cnt + 4'd1;
                  if (shift_cnt == 4'd7) state_next = ST_DONE;
               end
            end
            ST_DONE: begin
               // Register is all ones here; further pulses change nothing.
               state_next = ST_DONE;
            end
            default: begin
               state_next = ST_LOAD;
            end
         endcase
      end
   end

   assign ctlr_data = ~sr[0];
   assign state_dbg = state;

endmodule

// File: tb/tb_ctlr_pad_responder.sv
// Testbench for ctlr_pad_responder.
// A pad-level model (delay queues for the synchronizers, a sample-history
// debouncer, and a "latched byte + bits read" view of the shift register)
// is checked against the DUT on every falling clock edge. Directed
// sequences add literal expectations for the documented scenarios.

module tb_ctlr_pad_responder;

   localparam int DB   = 4;
   localparam int SYNC = 2;

   // ---------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------
   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       clock_en    = 1'b1;
   logic [7:0] buttons_raw = 8'h00;
   logic       ctlr_latch  = 1'b0;
   logic       ctlr_pulse  = 1'b0;
   logic       ctlr_data;
   logic [7:0] buttons_db;
   logic [3:0] shift_cnt;
   logic [1:0] state_dbg;

   always #5 clock = ~clock;

   ctlr_pad_responder #(
      .DEBOUNCE_CYCLES (DB),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .clock_en    (clock_en),
      .buttons_raw (buttons_raw),
      .ctlr_latch  (ctlr_latch),
      .ctlr_pulse  (ctlr_pulse),
      .ctlr_data   (ctlr_data),
      .buttons_db  (buttons_db),
      .shift_cnt   (shift_cnt),
      .state_dbg   (state_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------------------------------------------------------
   // Pad model
   // ---------------------------------------------------------------
   logic [7:0] btn_q [$];
   logic       lat_q [$];
   logic       pul_q [$];
   logic [7:0] m_hist [DB];     // last DB synchronized samples, [0] newest
   logic [7:0] m_db      = 8'h00;
   logic [7:0] m_latched = 8'h00;
   int         m_n       = 0;   // bits read since last latch, capped at 8
   logic       m_prev    = 1'b0;

   task automatic model_reset();
      btn_q = {};
      lat_q = {};
      pul_q = {};
      for (int i = 0; i < SYNC; i++) begin
         btn_q.push_back(8'h00);
         lat_q.push_back(1'b0);
         pul_q.push_back(1'b0);
      end
      for (int i = 0; i < DB; i++) m_hist[i] = 8'h00;
      m_db      = 8'h00;
      m_latched = 8'h00;
      m_n       = 0;
      m_prev    = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] b;
      logic       l;
      logic       p;
      logic       rise;
      logic       all_diff;
      b = btn_q.pop_front();
      l = lat_q.pop_front();
      p = pul_q.pop_front();
      btn_q.push_back(buttons_raw);
      lat_q.push_back(ctlr_latch);
      pul_q.push_back(ctlr_pulse);
      rise   = p && !m_prev;
      m_prev = p;
      // Load sees the debounced value as it stood before this edge.
      if (l) begin
         m_latched = m_db;
         m_n       = 0;
      end else if (rise && m_n < 8) begin
         m_n++;
      end
      for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = b;
      for (int k = 0; k < 8; k++) begin
         all_diff = 1'b1;
         for (int i = 0; i < DB; i++)
            if (m_hist[i][k] == m_db[k]) all_diff = 1'b0;
         if (all_diff) m_db[k] = ~m_db[k];
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else if (clock_en) model_step();
   end

   // Compare process
   always @(negedge clock) begin
      logic exp_data;
      exp_data = (m_n < 8) ? ~m_latched[m_n] : 1'b0;
      chk("cmp_data", 8'(ctlr_data), 8'(exp_data));
      chk("cmp_db", buttons_db, m_db);
      chk("cmp_cnt", 8'(shift_cnt), 8'((m_n < 8) ? m_n : 8));
   end

   // ---------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------
   logic [0:0] exp_q [$];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic pulse();
      ctlr_pulse = 1'b1;
      step(6);
      ctlr_pulse = 1'b0;
      step(6);
   endtask

   task automatic do_latch();
      ctlr_latch = 1'b1;
      step(6);
      ctlr_latch = 1'b0;
      step(6);
   endtask

   // Check ctlr_data against each queued bit before issuing that pulse.
   task automatic read_queue(input string tag);
      logic [0:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(tag, 8'(ctlr_data), 8'(e));
         pulse();
      end
   endtask

   // ---------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------
   initial begin
      // Reset
      step(3);
      chk("rst_data", 8'(ctlr_data), 8'h01);
      chk("rst_cnt", 8'(shift_cnt), 8'h00);
      chk("rst_db", buttons_db, 8'h00);
      reset_n = 1'b1;
      step(2);
      for (int i = 0; i < 3; i++) begin
         pulse();
         chk("nolatch_data", 8'(ctlr_data), 8'h01);
      end

      // Basic read: A + Start
      buttons_raw = 8'h09;
      step(10);
      chk("basic_db", buttons_db, 8'h09);
      do_latch();
      exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      read_queue("basic_bit");
      chk("basic_cnt", 8'(shift_cnt), 8'h08);
      chk("basic_tail", 8'(ctlr_data), 8'h00);

      // Over-read with everything pressed
      buttons_raw = 8'hFF;
      step(10);
      do_latch();
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      read_queue("over_bit");
      chk("over_cnt", 8'(shift_cnt), 8'h08);

      // Latch dominance
      buttons_raw = 8'h01;
      step(10);
      ctlr_latch = 1'b1;
      step(6);
      chk("dom_data_a", 8'(ctlr_data), 8'h00);
      pulse();
      pulse();
      chk("dom_cnt_a", 8'(shift_cnt), 8'h00);
      buttons_raw = 8'h80;
      pulse();
      pulse();
      chk("dom_data_b", 8'(ctlr_data), 8'h01);
      chk("dom_cnt_b", 8'(shift_cnt), 8'h00);
      ctlr_latch = 1'b0;
      step(6);
      exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      read_queue("dom_bit");

      // Debounce: 3-cycle glitch, then a held level
      buttons_raw = 8'h00;
      step(10);
      buttons_raw = 8'h04;
      step(3);
      buttons_raw = 8'h00;
      step(10);
      chk("glitch_db", buttons_db, 8'h00);
      buttons_raw = 8'h04;
      step(SYNC + DB - 1);
      chk("db_early", buttons_db, 8'h00);
      step(1);
      chk("db_exact", buttons_db, 8'h04);

      // clock_en low freezes the debouncer
      clock_en    = 1'b0;
      buttons_raw = 8'h01;
      step(20);
      chk("freeze_db", buttons_db, 8'h04);
      clock_en = 1'b1;
      step(SYNC + DB - 1);
      chk("unfreeze_early", buttons_db, 8'h04);
      step(1);
      chk("unfreeze_db", buttons_db, 8'h01);

      // Reset mid-shift
      buttons_raw = 8'h09;
      step(10);
      do_latch();
      pulse();
      pulse();
      pulse();
      chk("pre_rst_cnt", 8'(shift_cnt), 8'h03);
      reset_n = 1'b0;
      #1;
      chk("midrst_cnt", 8'(shift_cnt), 8'h00);
      chk("midrst_data", 8'(ctlr_data), 8'h01);
      chk("midrst_db", buttons_db, 8'h00);
      step(1);
      reset_n = 1'b1;
      step(10);
      do_latch();
      exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      read_queue("post_rst_bit");
      chk("post_rst_cnt", 8'(shift_cnt), 8'h08);

      step(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
